trdb_packet_emitter: RTL

Byte serializer sitting directly downstream of `trace_debugger`. It captures each packet (`packet_type`, `packet_length`, `packet_payload`) the encoder produces and buffers it in a small FIFO. It then emits the packet as a header byte followed by payload bytes on a valid/ready byte stream toward the trace sink (FIFO, UART or DMA front end). The upstream encoder is never stalled: packets arriving while the buffer is full are dropped and counted.

---
 rtl/trdb_packet_emitter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/trdb_packet_emitter.sv
// Packet-to-byte serializer behind trace_debugger: buffers whole packets in a small FIFO
// and streams a {type,length} header followed by payload bytes (LSB first) on valid/ready.
module trdb_packet_emitter #(
   parameter int PTYPE_LEN   = 3,
   parameter int P_LEN       = 5,
   parameter int PAYLOAD_LEN = 248,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   packet_valid_i,
   input  logic [PTYPE_LEN-1:0]   packet_type_i,
   input  logic [P_LEN-1:0]       packet_length_i,
   input  logic [PAYLOAD_LEN-1:0] packet_payload_i,
   output logic                   packet_ready_o,
   output logic                   byte_valid_o,
   input  logic                   byte_ready_i,
   output logic [7:0]             byte_data_o,
   output logic                   byte_last_o,
   output logic [7:0]             drop_cnt_o,
   output logic                   busy_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   if (PTYPE_LEN + P_LEN != 8) begin : g_bad_header_width
      $error("PTYPE_LEN + P_LEN must equal 8");
   end

   typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_t;

   logic [PTYPE_LEN-1:0]   r_fifo_type [FIFO_DEPTH];
   logic [P_LEN-1:0]       r_fifo_len  [FIFO_DEPTH];
   logic [PAYLOAD_LEN-1:0] r_fifo_pay  [FIFO_DEPTH];
   logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
   logic [AW:0]            r_count;

   state_t                 r_state;
   logic [P_LEN-1:0]       r_sh_len, r_idx;
   logic [PAYLOAD_LEN-1:0] r_sh_pay;

   logic                   r_byte_valid, r_byte_last, r_busy, r_pkt_ready;
   logic [7:0]             r_byte_data, r_drop_cnt;

   logic                   w_full, w_empty, w_push, w_drop, w_hs, w_done, w_pop, w_active_nxt;
   logic [AW:0]            w_count_nxt;
   logic [P_LEN-1:0]       w_idx_nxt, w_last_idx;
   logic [PTYPE_LEN-1:0]   w_head_type;
   logic [P_LEN-1:0]       w_head_len;
   logic [PAYLOAD_LEN-1:0] w_head_pay;

   function automatic logic [7:0] get_byte(input logic [PAYLOAD_LEN-1:0] pay,
                                           input logic [P_LEN-1:0] idx);
      return 8'(pay >> {idx, 3'b000});
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign w_full       = (r_count == FULL_CNT);
   assign w_empty      = (r_count == '0);
   assign w_push       = packet_valid_i && !w_full;
   assign w_drop       = packet_valid_i && w_full;
   assign w_hs         = r_byte_valid && byte_ready_i;
   assign w_last_idx   = r_sh_len - P_LEN'(1);
   assign w_idx_nxt    = r_idx + P_LEN'(1);
   assign w_done       = w_hs && (((r_state == S_HEADER) && (r_sh_len == '0)) ||
                                  ((r_state == S_PAYLOAD) && (r_idx == w_last_idx)));
   // Pop either from IDLE or on the closing handshake, so back-to-back packets have no bubble.
   assign w_pop        = !w_empty && ((r_state == S_IDLE) || w_done);
   assign w_active_nxt = w_pop || ((r_state != S_IDLE) && !w_done);
   assign w_head_type  = r_fifo_type[r_rd_ptr];
   assign w_head_len   = r_fifo_len[r_rd_ptr];
   assign w_head_pay   = r_fifo_pay[r_rd_ptr];

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)
         w_count_nxt = r_count + (AW+1)'(1);
      else if (!w_push && w_pop)
         w_count_nxt = r_count - (AW+1)'(1);
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_type[r_wr_ptr] <= packet_type_i;
         r_fifo_len[r_wr_ptr]  <= packet_length_i;
         r_fifo_pay[r_wr_ptr]  <= packet_payload_i;
      end
      if (w_pop)
         r_sh_pay <= w_head_pay;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_drop_cnt  <= '0;
         r_busy      <= 1'b0;
         r_pkt_ready <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
         r_count     <= w_count_nxt;
         r_busy      <= w_active_nxt || (w_count_nxt != '0);
         r_pkt_ready <= (w_count_nxt != FULL_CNT);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_sh_len     <= '0;
         r_idx        <= '0;
         r_byte_valid <= 1'b0;
         r_byte_data  <= '0;
         r_byte_last  <= 1'b0;
      end else if (w_pop) begin
         r_state      <= S_HEADER;
         r_sh_len     <= w_head_len;
         r_byte_valid <= 1'b1;
         r_byte_data  <= {w_head_type, w_head_len};
         r_byte_last  <= (w_head_len == '0);
      end else if (w_done) begin
         r_state      <= S_IDLE;
         r_byte_valid <= 1'b0;
         r_byte_data  <= '0;
         r_byte_last  <= 1'b0;
      end else if (w_hs) begin
         case (r_state)
            S_HEADER: begin
               r_state     <= S_PAYLOAD;
               r_idx       <= '0;
               r_byte_data <= get_byte(r_sh_pay, '0);
               r_byte_last <= (r_sh_len == P_LEN'(1));
            end
            S_PAYLOAD: begin
               r_idx       <= w_idx_nxt;
               r_byte_data <= get_byte(r_sh_pay, w_idx_nxt);
               r_byte_last <= (w_idx_nxt == w_last_idx);
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign packet_ready_o = r_pkt_ready;
   assign byte_valid_o   = r_byte_valid;
   assign byte_data_o    = r_byte_data;
   assign byte_last_o    = r_byte_last;
   assign drop_cnt_o     = r_drop_cnt;
   assign busy_o         = r_busy;

endmodule
